seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver. Watches the time-multiplexed segment bus (abcdefgh) and the one-hot digit strobe, then rebuilds the hex number and dot vector being shown.
- Used for on-chip loopback self-check of display paths and as a bench monitor. Sits directly on the driver's output pins.

Parameters:
- w_digit, 2, number of multiplexed digits (>= 1).
- stable_cycles, 4, consecutive identical input cycles required before a digit is sampled (>= 2).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- abcdefgh  input  8  segment bus, bit7 = a … bit1 = g, bit0 = h (dot)
- digit  input  w_digit  digit strobe, one-hot when a digit is lit
- number  output  w_digit*4  last complete captured frame, digit i in bits [4i+3:4i]
- dots  output  w_digit  last complete captured dot vector
- frame_valid  output  1  one-cycle pulse when number/dots update
- code_error  output  1  one-cycle pulse when a sampled pattern is not a legal hex glyph

Behaviour:
- Inputs are registered once (r_seg, r_dig) before all other logic. Everything below refers to the registered values.
- Glyph table (a..g), digits 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1110011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Dot = bit0, taken independently of the glyph.
- Stability counter cnt (width $clog2(stable_cycles)):
  - cleared when (r_seg, r_dig) differs from its previous-cycle value;
  - otherwise increments, saturating at stable_cycles-1.
- FSM states:
  - WAIT: r_dig is not one-hot (zero or multiple bits set). Holds here; cnt cleared.
  - SETTLE: r_dig is one-hot; waiting for cnt == stable_cycles-1.
  - HELD: current dwell already sampled; waits for an input change.
- FSM transitions:
  - WAIT -> SETTLE when r_dig is one-hot.
  - SETTLE -> HELD on the edge where cnt == stable_cycles-1 and the input is unchanged. On that edge the glyph decode and dot are written into shadow slot index(r_dig), and mask[index] is set.
  - SETTLE or HELD -> WAIT if r_dig stops being one-hot.
  - SETTLE or HELD -> SETTLE (cnt = 0) on any input change that stays one-hot.
- Illegal glyph at sample time:
  - slot written with 0 and mask bit still set;
  - code_error pulses high in the cycle after the sample edge.
- Frame completion:
  - When the sample edge makes mask all-ones, number/dots load from the shadow (including the slot just written) on the next edge.
  - frame_valid is high for exactly that one cycle; mask clears in the same cycle.
- Sampling the same digit twice before the frame completes overwrites that slot. No error is raised.
- Latency: from the raw input becoming stable, the final digit of a frame reaches number/dots at stable_cycles+2 edges.
- Reset values: number = 0, dots = 0, frame_valid = 0, code_error = 0, mask = 0, shadow = 0, cnt = 0, state = WAIT.
- Reset mid-frame discards partial capture.

Optional Feature:
- Macro: SEVEN_SEGMENT_CAPTURE_ACTIVE_LOW_EN.
- Defined: abcdefgh and digit are inverted at the input register, for boards with common-anode displays and active-low strobes. Behaviour after inversion is identical.
- Undefined: inputs are active-high as listed.

Decomposition:
- Package seven_segment_pkg holds:
  - the 16-entry glyph constant array (7-bit patterns);
  - the FSM state enum {WAIT, SETTLE, HELD};
  - the dot bit index constant.
- Sub-module seven_segment_decode: combinational 7-bit pattern -> {legal, nibble[3:0]}. It is shared with future segment-based monitors.

Test Plan:
- Two-digit driver model shows 0x3A, dots 2'b10, each digit held 8 cycles, stable_cycles = 4 -> frame_valid pulses once per full scan, number = 8'h3A, dots = 2'b10, code_error never asserted.
- Digit 0 held only 3 cycles (< stable_cycles) -> no sample, mask unchanged, no frame_valid until a full-dwell scan.
- Digit 1 shows pattern 0000001 (illegal) -> code_error pulse one cycle after sample; completed frame has digit1 = 0.
- Strobe 2'b11, then 2'b00 for 20 cycles -> FSM stays in WAIT, no sample, outputs hold previous frame.
- rst asserted after digit 0 captured, before digit 1 -> number = 0 and mask = 0 next cycle; first frame_valid only after both digits recaptured.
- Build with SEVEN_SEGMENT_CAPTURE_ACTIVE_LOW_EN, inverted stimulus for 0x7F -> number = 8'h7F, frame_valid pulse as in the first scenario.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared glyph table, FSM states and dot index for seven-segment monitors
package seven_segment_pkg;

    // Segment patterns a..g (bit6 = a, bit0 = g) for hex digits 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam int DOT_BIT = 0;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_e;

endpackage

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational 7-segment pattern to hex nibble decoder with legality flag
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_legal  = 1'b0;
        o_nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == GLYPHS[i]) begin
                o_legal  = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - rebuilds hex number and dots from a multiplexed seven-segment bus
// Define SEVEN_SEGMENT_CAPTURE_ACTIVE_LOW_EN for common-anode segments and active-low strobes.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int w_digit       = 2,
    parameter int stable_cycles = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           abcdefgh,
    input  logic [w_digit-1:0]   digit,
    output logic [w_digit*4-1:0] number,
    output logic [w_digit-1:0]   dots,
    output logic                 frame_valid,
    output logic                 code_error
);

    localparam int CW = (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
    localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(stable_cycles - 1);

    logic [7:0]           w_seg_in;
    logic [w_digit-1:0]   w_dig_in;

`ifdef SEVEN_SEGMENT_CAPTURE_ACTIVE_LOW_EN
    assign w_seg_in = ~abcdefgh;
    assign w_dig_in = ~digit;
`else
    assign w_seg_in = abcdefgh;
    assign w_dig_in = digit;
`endif

    logic [7:0]           r_seg;
    logic [w_digit-1:0]   r_dig;
    logic [7:0]           r_seg_q;
    logic [w_digit-1:0]   r_dig_q;
    logic [CW-1:0]        r_cnt;
    state_e               r_state;
    state_e               w_state_next;
    logic                 w_sample;
    logic                 w_changed;
    logic                 w_onehot;
    logic [IW-1:0]        w_idx;
    logic                 w_legal;
    logic [3:0]           w_nibble;
    logic                 w_complete;

    logic [3:0]           r_shadow [w_digit];
    logic [w_digit-1:0]   r_shadow_dots;
    logic [w_digit-1:0]   r_mask;
    logic                 r_frame_pend;
    logic [w_digit*4-1:0] r_number;
    logic [w_digit-1:0]   r_dots;
    logic                 r_frame_valid;
    logic                 r_code_error;

    // r_*_q is the previous registered value, used only for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= '0;
            r_dig   <= '0;
            r_seg_q <= '0;
            r_dig_q <= '0;
        end else begin
            r_seg   <= w_seg_in;
            r_dig   <= w_dig_in;
            r_seg_q <= r_seg;
            r_dig_q <= r_dig;
        end
    end

    assign w_changed = (r_seg != r_seg_q) || (r_dig != r_dig_q);
    assign w_onehot  = $onehot(r_dig);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == WAIT || w_changed) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            WAIT: begin
                if (w_onehot) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!w_onehot) begin
                    w_state_next = WAIT;
                end else if (w_changed) begin
                    w_state_next = SETTLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = HELD;
                    w_sample     = 1'b1;
                end
            end
            HELD: begin
                if (!w_onehot) begin
                    w_state_next = WAIT;
                end else if (w_changed) begin
                    w_state_next = SETTLE;
                end
            end
            default: begin
                w_state_next = WAIT;
            end
        endcase
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (r_dig[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    seven_segment_decode u_decode (
        .i_pattern (r_seg[7:1]),
        .o_legal   (w_legal),
        .o_nibble  (w_nibble)
    );

    // r_dig is one-hot whenever w_sample is high, so it doubles as the mask bit.
    assign w_complete = w_sample && ((r_mask | r_dig) == {w_digit{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < w_digit; i++) begin
                r_shadow[i] <= 4'd0;
            end
            r_shadow_dots <= '0;
            r_mask        <= '0;
            r_frame_pend  <= 1'b0;
            r_number      <= '0;
            r_dots        <= '0;
            r_frame_valid <= 1'b0;
            r_code_error  <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_code_error  <= w_sample && !w_legal;
            r_frame_pend  <= w_complete;
            if (w_sample) begin
                r_shadow[w_idx]      <= w_legal ? w_nibble : 4'd0;
                r_shadow_dots[w_idx] <= r_seg[DOT_BIT];
                r_mask               <= r_mask | r_dig;
            end
            if (r_frame_pend) begin
                for (int i = 0; i < w_digit; i++) begin
                    r_number[4*i +: 4] <= r_shadow[i];
                end
                r_dots        <= r_shadow_dots;
                r_frame_valid <= 1'b1;
                r_mask        <= '0;
            end
        end
    end

    assign number      = r_number;
    assign dots        = r_dots;
    assign frame_valid = r_frame_valid;
    assign code_error  = r_code_error;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - self-checking bench for seven_segment_capture
module tb_seven_segment_capture;

    localparam int W  = 2;
    localparam int ST = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     abcdefgh;
    logic [W-1:0]   digit;
    logic [W*4-1:0] number;
    logic [W-1:0]   dots;
    logic           frame_valid;
    logic           code_error;

    // Logical (active-high) stimulus; pins are derived from it.
    logic [7:0]     drv_seg = 8'h00;
    logic [W-1:0]   drv_dig = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_count = 0;
    int ce_count = 0;
    bit checking = 1'b0;

`ifdef SEVEN_SEGMENT_CAPTURE_ACTIVE_LOW_EN
    assign abcdefgh = ~drv_seg;
    assign digit    = ~drv_dig;
`else
    assign abcdefgh = drv_seg;
    assign digit    = drv_dig;
`endif

    seven_segment_capture #(
        .w_digit       (W),
        .stable_cycles (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .number      (number),
        .dots        (dots),
        .frame_valid (frame_valid),
        .code_error  (code_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the registered input must hold one one-hot value for ST+1 cycles
    // before it is sampled once; a full mask publishes the frame one edge later.
    logic [7:0]     m_seg;
    logic [W-1:0]   m_dig;
    int             m_run;
    logic [3:0]     m_nib [W];
    logic [W-1:0]   m_sdot;
    logic [W-1:0]   m_mask;
    bit             m_load;
    int             m_idx;
    bit             m_legal;
    logic [3:0]     m_val;
    logic [W*4-1:0] e_num;
    logic [W-1:0]   e_dots;
    logic           e_fv;
    logic           e_ce;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_seg  = 8'h00;
                m_dig  = '0;
                m_run  = 1;
                for (int i = 0; i < W; i++) m_nib[i] = 4'd0;
                m_sdot = '0;
                m_mask = '0;
                m_load = 1'b0;
                e_num  = '0;
                e_dots = '0;
                e_fv   = 1'b0;
                e_ce   = 1'b0;
            end else begin
                e_fv = 1'b0;
                e_ce = 1'b0;
                if (m_load) begin
                    for (int i = 0; i < W; i++) e_num[4*i +: 4] = m_nib[i];
                    e_dots = m_sdot;
                    e_fv   = 1'b1;
                    m_mask = '0;
                    m_load = 1'b0;
                end
                if ($onehot(m_dig) && m_run == ST + 1) begin
                    m_idx = 0;
                    for (int i = 0; i < W; i++) if (m_dig[i]) m_idx = i;
                    m_legal = 1'b0;
                    m_val   = 4'd0;
                    for (int g = 0; g < 16; g++) begin
                        if (m_seg[7:1] == GLYPH[g]) begin
                            m_legal = 1'b1;
                            m_val   = 4'(g);
                        end
                    end
                    m_nib[m_idx]  = m_val;
                    m_sdot[m_idx] = m_seg[0];
                    m_mask        = m_mask | m_dig;
                    e_ce          = !m_legal;
                    if (&m_mask) m_load = 1'b1;
                end
                if (drv_seg == m_seg && drv_dig == m_dig) begin
                    if (m_run < 1000) m_run++;
                end else begin
                    m_seg = drv_seg;
                    m_dig = drv_dig;
                    m_run = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("number", number, e_num);
                check("dots", dots, e_dots);
                check("frame_valid", frame_valid, e_fv);
                check("code_error", code_error, e_ce);
                if (frame_valid === 1'b1) fv_count++;
                if (code_error === 1'b1) ce_count++;
            end
        end
    end

    task automatic show(input logic [3:0] nib, input logic dp, input logic [W-1:0] dig, input int n);
        drv_seg = {GLYPH[nib], dp};
        drv_dig = dig;
        repeat (n) @(negedge clk);
    endtask

    task automatic show_raw(input logic [7:0] seg, input logic [W-1:0] dig, input int n);
        drv_seg = seg;
        drv_dig = dig;
        repeat (n) @(negedge clk);
    endtask

    int fv0;
    int ce0;
    int lat;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        #1;
        check("reset_number", number, 8'h00);
        check("reset_dots", dots, 2'b00);
        check("reset_frame_valid", frame_valid, 1'b0);
        check("reset_code_error", code_error, 1'b0);
        rst = 1'b0;

        // Two-digit scan of 0x3A with dot on digit 1; last scan measures latency.
        fv0 = fv_count;
        ce0 = ce_count;
        repeat (2) begin
            show(4'hA, 1'b0, 2'b01, 8);
            show(4'h3, 1'b1, 2'b10, 8);
        end
        show(4'hA, 1'b0, 2'b01, 8);
        drv_seg = {GLYPH[3], 1'b1};
        drv_dig = 2'b10;
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (frame_valid === 1'b1) break;
        end
        check("latency_edges", lat, ST + 2);
        repeat (2) @(negedge clk);
        #1;
        check("scan_frames", fv_count - fv0, 3);
        check("scan_number", number, 8'h3A);
        check("scan_dots", dots, 2'b10);
        check("scan_no_error", ce_count - ce0, 0);

        // Short dwell on digit 0 is ignored.
        fv0 = fv_count;
        show(4'h5, 1'b0, 2'b01, 3);
        show(4'h3, 1'b0, 2'b10, 8);
        #1;
        check("short_dwell_no_frame", fv_count - fv0, 0);
        check("short_dwell_hold", number, 8'h3A);
        show(4'h5, 1'b0, 2'b01, 8);
        #1;
        check("short_dwell_recover", fv_count - fv0, 1);
        check("short_dwell_number", number, 8'h35);

        // Illegal glyph (g only) on digit 1.
        fv0 = fv_count;
        ce0 = ce_count;
        show(4'h7, 1'b0, 2'b01, 8);
        show_raw({7'b0000001, 1'b0}, 2'b10, 8);
        #1;
        check("illegal_error_pulses", ce_count - ce0, 1);
        check("illegal_frame", fv_count - fv0, 1);
        check("illegal_number", number, 8'h07);
        check("illegal_dots", dots, 2'b00);

        // Non-one-hot strobes never sample.
        fv0 = fv_count;
        ce0 = ce_count;
        show(4'h8, 1'b1, 2'b11, 10);
        show(4'h8, 1'b1, 2'b00, 20);
        #1;
        check("wait_no_frame", fv_count - fv0, 0);
        check("wait_no_error", ce_count - ce0, 0);
        check("wait_hold_number", number, 8'h07);

        // Reset after digit 0 is captured discards the partial frame.
        fv0 = fv_count;
        show(4'h1, 1'b0, 2'b01, 8);
        show_raw(8'h00, 2'b00, 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_number", number, 8'h00);
        check("midreset_dots", dots, 2'b00);
        rst = 1'b0;
        show(4'h2, 1'b0, 2'b10, 8);
        #1;
        check("midreset_partial", fv_count - fv0, 0);
        show(4'h1, 1'b0, 2'b01, 8);
        #1;
        check("midreset_recapture", fv_count - fv0, 1);
        check("midreset_number2", number, 8'h21);

        // 0x7F scan (inverted on the pins in the active-low build).
        fv0 = fv_count;
        repeat (2) begin
            show(4'hF, 1'b0, 2'b01, 8);
            show(4'h7, 1'b0, 2'b10, 8);
        end
        #1;
        check("scan7f_frames", fv_count - fv0, 2);
        check("scan7f_number", number, 8'h7F);
        check("scan7f_dots", dots, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
